// File: rtl/mdu_seq_if.sv
// Pipeline-facing bundle for the sequential multiply/divide unit. The
// pipeline side (master) drives the instructions, the forwarded E-stage
// operands and the flush; the unit (slave) returns busy/stall, the
// mfhi/mflo read data and the architectural HI/LO registers.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);

  logic [31:0]      instr_d;
  logic [31:0]      instr_e;
  logic [WIDTH-1:0] rs_e;
  logic [WIDTH-1:0] rt_e;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] rdata_e;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output instr_d,
    output instr_e,
    output rs_e,
    output rt_e,
    output cancel,
    input  busy,
    input  stall,
    input  rdata_e,
    input  hi,
    input  lo
  );

  modport slave (
    input  instr_d,
    input  instr_e,
    input  rs_e,
    input  rt_e,
    input  cancel,
    output busy,
    output stall,
    output rdata_e,
    output hi,
    output lo
  );

endinterface

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers. mult/multu and
// div/divu latch their operands and occupy the unit for a fixed number of
// cycles; the result is committed to HI/LO on the edge that ends the busy
// period. A flush (cancel) or reset abandons the operation with HI/LO intact
// (reset additionally clears HI/LO).
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_seq_if.slave bus
);

  // Counter is wide enough for the largest legal cycle count (64).
  localparam int CW = 7;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Any of the eight HI/LO instructions: SPECIAL opcode plus a listed funct.
  function automatic logic is_mdu(input logic [31:0] instr);
    logic special;
    special = (instr[31:26] == 6'd0);
    case (instr[5:0])
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: is_mdu = special;
      default:                        is_mdu = 1'b0;
    endcase
  endfunction

  logic e_special;
  logic mfhi_e, mthi_e, mflo_e, mtlo_e;
  logic mul_e, div_e;
  logic start;
  logic mdu_d;

  assign e_special = (bus.instr_e[31:26] == 6'd0);
  assign mfhi_e    = e_special && (bus.instr_e[5:0] == F_MFHI);
  assign mthi_e    = e_special && (bus.instr_e[5:0] == F_MTHI);
  assign mflo_e    = e_special && (bus.instr_e[5:0] == F_MFLO);
  assign mtlo_e    = e_special && (bus.instr_e[5:0] == F_MTLO);
  assign mul_e     = e_special && ((bus.instr_e[5:0] == F_MULT) ||
                                   (bus.instr_e[5:0] == F_MULTU));
  assign div_e     = e_special && ((bus.instr_e[5:0] == F_DIV) ||
                                   (bus.instr_e[5:0] == F_DIVU));
  assign mdu_d     = is_mdu(bus.instr_d);

  // Reset behaves like a flush for the purpose of launching an operation.
  assign start = (mul_e || div_e) && (state == IDLE) && !bus.cancel && !reset;

  // Register-field bits of the instructions do not matter to this unit.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr_e[25:6], bus.instr_d[25:6]};

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  // Extending both operands to 2*WIDTH (sign or zero) makes one truncated
  // multiply produce the correct signed or unsigned full-width product.
  always_comb begin
    ext_a   = {{WIDTH{op_signed & op_a[WIDTH-1]}}, op_a};
    ext_b   = {{WIDTH{op_signed & op_b[WIDTH-1]}}, op_b};
    product = ext_a * ext_b;
  end

  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Sign-magnitude division: divide magnitudes unsigned, then restore signs
  // so the quotient truncates toward zero and the remainder follows the
  // dividend. MIN / -1 falls out naturally as quotient MIN, remainder 0. A
  // zero divisor is replaced by 1 only to keep the datapath defined; its
  // result is never committed.
  always_comb begin
    a_neg    = op_signed & op_a[WIDTH-1];
    b_neg    = op_signed & op_b[WIDTH-1];
    div_zero = (op_b == '0);
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;
    if (div_zero) begin
      mag_b = WIDTH'(1);
    end
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  // Control FSM plus HI/LO: launch, count down, commit on the final count,
  // with cancel taking priority over the commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= bus.rs_e;
            op_b      <= bus.rt_e;
            op_signed <= ~bus.instr_e[0];
            if (mul_e) begin
              state <= MUL;
              count <= CW'(MUL_CYCLES);
            end else begin
              state <= DIV;
              count <= CW'(DIV_CYCLES);
            end
          end else if (!bus.cancel) begin
            if (mthi_e) hi_q <= bus.rs_e;
            if (mtlo_e) lo_q <= bus.rs_e;
          end
        end
        MUL: begin
          if (bus.cancel) begin
            state <= IDLE;
            count <= '0;
          end else if (count == CW'(1)) begin
            hi_q  <= product[2*WIDTH-1:WIDTH];
            lo_q  <= product[WIDTH-1:0];
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count - CW'(1);
          end
        end
        DIV: begin
          if (bus.cancel) begin
            state <= IDLE;
            count <= '0;
          end else if (count == CW'(1)) begin
            if (!div_zero) begin
              hi_q <= rem;
              lo_q <= quot;
            end
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // mfhi/mflo read port for the E stage; zero for anything else.
  always_comb begin
    bus.rdata_e = '0;
    if (mfhi_e) begin
      bus.rdata_e = hi_q;
    end else if (mflo_e) begin
      bus.rdata_e = lo_q;
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = (bus.busy || start) && mdu_d;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width in bits (legal 8..64).
REQ-002 SHALL have parameter MUL_CYCLES, default 5, busy cycles for mult/multu (legal 1..64).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal 1..64).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port instr_d  input  32  instruction in D stage.
REQ-007 SHALL have port instr_e  input  32  instruction in E stage.
REQ-008 SHALL have ports rs_e and rt_e  input  WIDTH  forwarded E-stage operands.
REQ-009 SHALL have port cancel  input  1  flush: abort the in-flight operation and block the E-stage MDU instruction.
REQ-010 SHALL have port busy  output  1  operation in flight.
REQ-011 SHALL have port stall  output  1  freeze D stage.
REQ-012 SHALL have port rdata_e  output  WIDTH  mfhi/mflo result for E stage.
REQ-013 SHALL have ports hi and lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 SHALL decode an instruction as MDU only when op[31:26]==0 and funct is one of: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011.
REQ-015 SHALL define start = instr_e is mult/multu/div/divu AND state==IDLE AND !cancel.
REQ-016 SHALL use states IDLE, MUL, DIV; IDLE->MUL or IDLE->DIV on start, capturing rs_e, rt_e, signedness and a down-counter loaded with MUL_CYCLES or DIV_CYCLES.
REQ-017 SHALL decrement the counter each cycle in MUL/DIV; when the counter is 1, write the result to HI/LO and return to IDLE on that same edge.
REQ-018 SHALL drive busy=1 exactly while state!=IDLE, so busy is high for exactly MUL_CYCLES or DIV_CYCLES cycles after the start edge.
REQ-019 SHALL make the new HI/LO visible in the first cycle that busy==0 after the operation.
REQ-020 mult/multu SHALL form a 2*WIDTH-bit signed or unsigned product, with HI = upper WIDTH bits and LO = lower WIDTH bits.
REQ-021 div/divu SHALL set LO = quotient (signed division truncates toward zero) and HI = remainder (remainder takes the sign of the dividend).
REQ-022 For a divisor of 0, div/divu SHALL still run DIV_CYCLES cycles and SHALL leave HI and LO unchanged.
REQ-023 For signed division of the most negative value by -1, div SHALL set LO = the most negative value and HI = 0.
REQ-024 mthi/mtlo in E SHALL write rs_e to HI/LO at the edge only when state==IDLE and !cancel; otherwise they SHALL have no effect.
REQ-025 rdata_e SHALL be a combinational output: hi for mfhi in E, lo for mflo in E, otherwise 0.
REQ-026 stall SHALL be combinational, equal to (busy OR start) AND instr_d is any MDU instruction per REQ-014.
REQ-027 cancel high while state!=IDLE SHALL return the block to IDLE at the next edge with HI/LO unchanged; busy SHALL fall in the following cycle.
REQ-028 cancel and a counter value of 1 in the same cycle SHALL resolve with cancel winning, leaving HI/LO unchanged.
REQ-029 An MDU instruction in E while busy SHALL not occur given stall, and the block SHALL ignore it (no restart, no HI/LO write).

Reset
REQ-030 reset high at an edge SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0, and discard any in-flight result.
REQ-031 While reset is high, stall SHALL equal 0 unless start logic is asserted, and start SHALL be suppressed (treated as cancel).

Verification
REQ-032 mult with rs=0xFFFFFFFE, rt=3, WIDTH=32 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 div with rs=-7, rt=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div with rs=7, rt=0 -> hi/lo keep their prior values 0x11/0x22.
REQ-034 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 mflo in D during the start cycle and during each busy cycle -> stall=1 throughout; stall=0 the cycle after busy falls, and rdata_e then returns the new lo.
REQ-036 cancel asserted on busy cycle 3 of a div -> busy falls after the next edge and HI/LO are unchanged; cancel together with mtlo in E -> lo is unchanged.
REQ-037 reset asserted mid-mult -> hi=lo=0 and busy=0 after the edge; a mult issued the next cycle completes normally.
